// File: rtl/mem_port_arbiter.sv
// mem_port_arbiter: round-robin arbiter that shares one synchronous RAM port between the
// instruction-fetch requester and the load/store data requester. One access is in flight
// at a time; read data returns with a one-cycle valid pulse after the RAM latency.
module mem_port_arbiter #(
   parameter int unsigned ADDR_W = 11,
   parameter int unsigned DATA_W = 32,
   parameter int unsigned RD_LAT = 2
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic              i_if_req,
   input  logic [ADDR_W-1:0] i_if_addr,
   output logic              o_if_gnt,
   output logic              o_if_rvalid,
   output logic [DATA_W-1:0] o_if_rdata,
   input  logic              i_dm_req,
   input  logic              i_dm_we,
   input  logic [ADDR_W-1:0] i_dm_addr,
   input  logic [DATA_W-1:0] i_dm_wdata,
   output logic              o_dm_gnt,
   output logic              o_dm_rvalid,
   output logic [DATA_W-1:0] o_dm_rdata,
   output logic [ADDR_W-1:0] o_ram_addr,
   output logic              o_ram_w_en,
   output logic [DATA_W-1:0] o_ram_wdata,
   input  logic [DATA_W-1:0] i_ram_rdata,
   output logic              o_busy
);

   typedef enum logic [1:0] {StIdle, StAccess, StWait, StDone} state_e;

   localparam logic OwnerIf = 1'b0;
   localparam logic OwnerDm = 1'b1;
   // WAIT is entered with RD_LAT-1 remaining; leaving at 1 lands DONE on the data cycle.
   localparam logic [2:0] CntLoad = 3'(RD_LAT - 1);

   state_e            r_state;
   state_e            w_state_next;
   logic              r_owner;
   logic              r_last_owner;
   logic              r_we;
   logic [ADDR_W-1:0] r_addr;
   logic [DATA_W-1:0] r_wdata;
   logic [2:0]        r_cnt;
   logic [2:0]        w_cnt_next;
   logic [DATA_W-1:0] r_if_rdata;
   logic [DATA_W-1:0] r_dm_rdata;
   logic              w_win;
   logic              w_win_owner;
   logic              w_done;

   // Next-state, latency counter and round-robin arbitration (requests seen only in IDLE).
   always_comb begin
      w_state_next = r_state;
      w_cnt_next   = r_cnt;
      w_win        = 1'b0;
      w_win_owner  = r_last_owner;
      case (r_state)
         StIdle: begin
            if (i_if_req && i_dm_req) begin
               w_win       = 1'b1;
               w_win_owner = ~r_last_owner;
            end else if (i_if_req) begin
               w_win       = 1'b1;
               w_win_owner = OwnerIf;
            end else if (i_dm_req) begin
               w_win       = 1'b1;
               w_win_owner = OwnerDm;
            end
            if (w_win) begin
               w_state_next = StAccess;
            end
         end
         StAccess: begin
            if (r_we) begin
               w_state_next = StIdle;
            end else if (RD_LAT == 1) begin
               w_state_next = StDone;
            end else begin
               w_state_next = StWait;
               w_cnt_next   = CntLoad;
            end
         end
         StWait: begin
            if (r_cnt == 3'd1) begin
               w_state_next = StDone;
            end else begin
               w_cnt_next = r_cnt - 3'd1;
            end
         end
         StDone: begin
            w_state_next = StIdle;
         end
         default: begin
            w_state_next = StIdle;
         end
      endcase
   end

   // State and latency counter registers.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_state <= StIdle;
         r_cnt   <= 3'd0;
      end else begin
         r_state <= w_state_next;
         r_cnt   <= w_cnt_next;
      end
   end

   // Latch the winning request; fetches are always reads.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_owner      <= OwnerIf;
         r_last_owner <= OwnerDm;
         r_we         <= 1'b0;
         r_addr       <= '0;
         r_wdata      <= '0;
      end else if (w_win) begin
         r_owner      <= w_win_owner;
         r_last_owner <= w_win_owner;
         if (w_win_owner == OwnerDm) begin
            r_we    <= i_dm_we;
            r_addr  <= i_dm_addr;
            r_wdata <= i_dm_wdata;
         end else begin
            r_we   <= 1'b0;
            r_addr <= i_if_addr;
         end
      end
   end

   // Capture returned read data into the owner's holding register at the end of DONE.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_if_rdata <= '0;
         r_dm_rdata <= '0;
      end else if (r_state == StDone) begin
         if (r_owner == OwnerIf) begin
            r_if_rdata <= i_ram_rdata;
         end else begin
            r_dm_rdata <= i_ram_rdata;
         end
      end
   end

   // Port and RAM outputs; rdata bypasses the holding register during DONE.
   always_comb begin
      w_done      = (r_state == StDone);
      o_if_gnt    = (r_state == StAccess) && (r_owner == OwnerIf);
      o_dm_gnt    = (r_state == StAccess) && (r_owner == OwnerDm);
      o_if_rvalid = w_done && (r_owner == OwnerIf);
      o_dm_rvalid = w_done && (r_owner == OwnerDm);
      o_if_rdata  = o_if_rvalid ? i_ram_rdata : r_if_rdata;
      o_dm_rdata  = o_dm_rvalid ? i_ram_rdata : r_dm_rdata;
      o_ram_addr  = r_addr;
      o_ram_w_en  = (r_state == StAccess) && r_we;
      o_ram_wdata = r_wdata;
      o_busy      = (r_state != StIdle);
   end

endmodule

// File: tb/tb_mem_port_arbiter.sv
// tb_mem_port_arbiter: directed scenarios plus randomized traffic checked against a
// transaction-level model (round-robin order, fixed occupancy, array-backed memory).
module tb_mem_port_arbiter;
   localparam int unsigned AW  = 11;
   localparam int unsigned DW  = 32;
   localparam int unsigned LAT = 2;

   logic clk = 1'b0;
   always #5 clk = ~clk;
   logic rst_n;

   logic          if_req, if_gnt, if_rvalid, dm_req, dm_we, dm_gnt, dm_rvalid;
   logic [AW-1:0] if_addr, dm_addr, ram_addr;
   logic [DW-1:0] if_rdata, dm_rdata, dm_wdata, ram_wdata, ram_rdata;
   logic          ram_w_en, busy;

   logic          if_req1, if_gnt1, if_rvalid1, dm_req1, dm_we1, dm_gnt1, dm_rvalid1;
   logic [AW-1:0] if_addr1, dm_addr1, ram_addr1;
   logic [DW-1:0] if_rdata1, dm_rdata1, dm_wdata1, ram_wdata1, ram_rdata1;
   logic          ram_w_en1, busy1;

   logic          bd_we;
   logic [AW-1:0] bd_addr;
   logic [DW-1:0] bd_data;

   mem_port_arbiter #(.ADDR_W(AW), .DATA_W(DW), .RD_LAT(LAT)) u_dut (
      .clk(clk), .rst_n(rst_n),
      .i_if_req(if_req), .i_if_addr(if_addr), .o_if_gnt(if_gnt), .o_if_rvalid(if_rvalid),
      .o_if_rdata(if_rdata), .i_dm_req(dm_req), .i_dm_we(dm_we), .i_dm_addr(dm_addr),
      .i_dm_wdata(dm_wdata), .o_dm_gnt(dm_gnt), .o_dm_rvalid(dm_rvalid), .o_dm_rdata(dm_rdata),
      .o_ram_addr(ram_addr), .o_ram_w_en(ram_w_en), .o_ram_wdata(ram_wdata),
      .i_ram_rdata(ram_rdata), .o_busy(busy)
   );

   mem_port_arbiter #(.ADDR_W(AW), .DATA_W(DW), .RD_LAT(1)) u_dut1 (
      .clk(clk), .rst_n(rst_n),
      .i_if_req(if_req1), .i_if_addr(if_addr1), .o_if_gnt(if_gnt1), .o_if_rvalid(if_rvalid1),
      .o_if_rdata(if_rdata1), .i_dm_req(dm_req1), .i_dm_we(dm_we1), .i_dm_addr(dm_addr1),
      .i_dm_wdata(dm_wdata1), .o_dm_gnt(dm_gnt1), .o_dm_rvalid(dm_rvalid1),
      .o_dm_rdata(dm_rdata1), .o_ram_addr(ram_addr1), .o_ram_w_en(ram_w_en1),
      .o_ram_wdata(ram_wdata1), .i_ram_rdata(ram_rdata1), .o_busy(busy1)
   );

   // RAM models: array plus read pipeline of RD_LAT stages; bd_* preloads contents.
   logic [DW-1:0] mem2 [2048];
   logic [DW-1:0] pipe2 [LAT];
   logic [DW-1:0] mem1 [2048];
   always @(posedge clk) begin
      if (bd_we) mem2[bd_addr] <= bd_data;
      else if (ram_w_en) mem2[ram_addr] <= ram_wdata;
      pipe2[0] <= mem2[ram_addr];
      for (int i = 1; i < LAT; i++) pipe2[i] <= pipe2[i-1];
   end
   assign ram_rdata = pipe2[LAT-1];
   always @(posedge clk) begin
      if (bd_we) mem1[bd_addr] <= bd_data;
      else if (ram_w_en1) mem1[ram_addr1] <= ram_wdata1;
      ram_rdata1 <= mem1[ram_addr1];
   end

   logic [DW-1:0] ref_mem [2048];
   logic [DW-1:0] init_mem [128];
   bit            ref_last_dm;
   int            n_checks = 0;
   int            n_pass   = 0;

   task automatic wait_idle();
      bit ok = 1'b0;
      for (int c = 0; c < 30; c++) begin
         @(negedge clk);
         if (!busy) begin ok = 1'b1; break; end
      end
      n_checks++;
      if (!ok) $display("FAIL wait_idle: busy still %b after 30 cycles, want 0", busy);
      else n_pass++;
   endtask

   task automatic test_reset();
      @(negedge clk);
      n_checks++;
      if ({if_gnt, if_rvalid, dm_gnt, dm_rvalid, ram_w_en, busy} !== 6'b0)
         $display("FAIL reset_flags: got %b want 000000",
                  {if_gnt, if_rvalid, dm_gnt, dm_rvalid, ram_w_en, busy});
      else n_pass++;
      n_checks++;
      if ({if_rdata, dm_rdata, ram_wdata, ram_addr} !== '0)
         $display("FAIL reset_data: got %h %h %h %h want all 0",
                  if_rdata, dm_rdata, ram_wdata, ram_addr);
      else n_pass++;
      rst_n = 1'b1;
      for (int k = 0; k < 3; k++) begin
         @(negedge clk);
         n_checks++;
         if ({busy, if_gnt, dm_gnt} !== 3'b0)
            $display("FAIL reset_idle: got busy/ig/dg %b want 000", {busy, if_gnt, dm_gnt});
         else n_pass++;
      end
      ref_last_dm = 1'b1;
   endtask

   task automatic test_fetch_read();
      if_req = 1'b1; if_addr = 11'h010;
      @(negedge clk);
      n_checks++;
      if ({if_gnt, dm_gnt, busy} !== 3'b101 || ram_addr !== 11'h010)
         $display("FAIL t1_gnt: got gnt/dgnt/busy %b addr %h want 101 010",
                  {if_gnt, dm_gnt, busy}, ram_addr);
      else n_pass++;
      if_req = 1'b0; if_addr = '0;
      @(negedge clk);
      n_checks++;
      if (if_rvalid !== 1'b0) $display("FAIL t1_early_rvalid: got %b want 0", if_rvalid);
      else n_pass++;
      @(negedge clk);
      n_checks++;
      if (if_rvalid !== 1'b1 || if_rdata !== 32'hE3A0_0001)
         $display("FAIL t1_rvalid: got %b %h want 1 e3a00001", if_rvalid, if_rdata);
      else n_pass++;
      @(negedge clk);
      n_checks++;
      if (if_rvalid !== 1'b0 || if_rdata !== 32'hE3A0_0001 || busy !== 1'b0)
         $display("FAIL t1_hold: got rv %b data %h busy %b want 0 e3a00001 0",
                  if_rvalid, if_rdata, busy);
      else n_pass++;
      ref_last_dm = 1'b0;
   endtask

   task automatic test_store();
      dm_req = 1'b1; dm_we = 1'b1; dm_addr = 11'h200; dm_wdata = 32'hDEAD_BEEF;
      @(negedge clk);
      n_checks++;
      if ({dm_gnt, if_gnt, ram_w_en, busy} !== 4'b1011 || ram_addr !== 11'h200 ||
          ram_wdata !== 32'hDEAD_BEEF)
         $display("FAIL t2_access: got g/ig/we/busy %b addr %h data %h want 1011 200 deadbeef",
                  {dm_gnt, if_gnt, ram_w_en, busy}, ram_addr, ram_wdata);
      else n_pass++;
      dm_req = 1'b0; dm_we = 1'b0; dm_wdata = '0;
      ref_mem[11'h200] = 32'hDEAD_BEEF;
      for (int k = 0; k < 2; k++) begin
         @(negedge clk);
         n_checks++;
         if ({dm_gnt, ram_w_en, busy, dm_rvalid} !== 4'b0)
            $display("FAIL t2_after: got g/we/busy/rv %b want 0000",
                     {dm_gnt, ram_w_en, busy, dm_rvalid});
         else n_pass++;
      end
      ref_last_dm = 1'b1;
   endtask

   task automatic test_fairness();
      int got[6];
      int n = 0;
      foreach (got[i]) got[i] = -1;
      rst_n = 1'b0;
      @(negedge clk);
      rst_n = 1'b1;
      if_req = 1'b1; if_addr = 11'h001;
      dm_req = 1'b1; dm_we = 1'b0; dm_addr = 11'h002;
      for (int c = 0; c < 80 && n < 6; c++) begin
         @(negedge clk);
         if (if_gnt && n < 6) begin got[n] = 0; n++; end
         if (dm_gnt && n < 6) begin got[n] = 1; n++; end
         if (n == 6) begin if_req = 1'b0; dm_req = 1'b0; end
      end
      if_req = 1'b0; dm_req = 1'b0;
      for (int i = 0; i < 6; i++) begin
         n_checks++;
         if (got[i] != i % 2)
            $display("FAIL t3_order[%0d]: got owner %0d want %0d (0=IF 1=DM)", i, got[i], i % 2);
         else n_pass++;
      end
      ref_last_dm = 1'b1;
      wait_idle();
   endtask

   task automatic test_store_load();
      logic [DW-1:0] d = $urandom;
      dm_req = 1'b1; dm_we = 1'b1; dm_addr = 11'h055; dm_wdata = d;
      @(negedge clk);
      n_checks++;
      if (dm_gnt !== 1'b1 || ram_w_en !== 1'b1)
         $display("FAIL t4_store: got gnt %b we %b want 1 1", dm_gnt, ram_w_en);
      else n_pass++;
      dm_we = 1'b0; dm_wdata = '0;
      ref_mem[11'h055] = d;
      @(negedge clk);
      n_checks++;
      if (busy !== 1'b0) $display("FAIL t4_idle: got busy %b want 0", busy);
      else n_pass++;
      @(negedge clk);
      n_checks++;
      if (dm_gnt !== 1'b1 || ram_w_en !== 1'b0 || ram_addr !== 11'h055)
         $display("FAIL t4_load_gnt: got gnt %b we %b addr %h want 1 0 055",
                  dm_gnt, ram_w_en, ram_addr);
      else n_pass++;
      dm_req = 1'b0;
      @(negedge clk);
      @(negedge clk);
      n_checks++;
      if (dm_rvalid !== 1'b1 || dm_rdata !== d)
         $display("FAIL t4_load_data: got %b %h want 1 %h", dm_rvalid, dm_rdata, d);
      else n_pass++;
      ref_last_dm = 1'b1;
      wait_idle();
   endtask

   task automatic test_reset_mid_wait();
      logic [DW-1:0] d = $urandom;
      bit ok = 1'b0;
      if_req = 1'b1; if_addr = 11'h020;
      @(posedge clk);
      @(negedge clk);
      n_checks++;
      if (if_gnt !== 1'b1) $display("FAIL t5_gnt: got %b want 1", if_gnt);
      else n_pass++;
      if_req = 1'b0;
      @(posedge clk);
      #2 rst_n = 1'b0;
      #1;
      n_checks++;
      if ({if_gnt, if_rvalid, dm_gnt, dm_rvalid, ram_w_en, busy} !== 6'b0)
         $display("FAIL t5_flags: got %b want 000000",
                  {if_gnt, if_rvalid, dm_gnt, dm_rvalid, ram_w_en, busy});
      else n_pass++;
      n_checks++;
      if ({if_rdata, dm_rdata, ram_wdata, ram_addr} !== '0)
         $display("FAIL t5_data: got %h %h %h %h want all 0",
                  if_rdata, dm_rdata, ram_wdata, ram_addr);
      else n_pass++;
      @(negedge clk);
      rst_n = 1'b1;
      for (int k = 0; k < 5; k++) begin
         @(negedge clk);
         n_checks++;
         if (if_rvalid !== 1'b0 || busy !== 1'b0)
            $display("FAIL t5_quiet: got rv %b busy %b want 0 0", if_rvalid, busy);
         else n_pass++;
      end
      if_req = 1'b1; if_addr = 11'h021;
      dm_req = 1'b1; dm_we = 1'b1; dm_addr = 11'h022; dm_wdata = d;
      @(negedge clk);
      n_checks++;
      if (if_gnt !== 1'b1 || dm_gnt !== 1'b0)
         $display("FAIL t5_first: got ig %b dg %b want 1 0", if_gnt, dm_gnt);
      else n_pass++;
      if_req = 1'b0;
      for (int c = 0; c < 20; c++) begin
         @(negedge clk);
         if (dm_gnt) begin ok = 1'b1; break; end
      end
      dm_req = 1'b0; dm_we = 1'b0;
      n_checks++;
      if (!ok) $display("FAIL t5_second: got no dm_gnt within 20 cycles, want one");
      else n_pass++;
      ref_mem[11'h022] = d;
      ref_last_dm = 1'b1;
      wait_idle();
   endtask

   task automatic test_random(input int rounds);
      bit            e_ig[32], e_dg[32], e_iv[32], e_dv[32], e_we[32], e_idle[32];
      logic [DW-1:0] e_data[32];
      logic [AW-1:0] e_addr[32];
      bit            has_if, has_dm, dwe, own, we;
      bit            ord[2];
      int            n, t;
      logic [AW-1:0] ia, da, a;
      logic [DW-1:0] dwd;
      for (int r = 0; r < rounds; r++) begin
         foreach (e_ig[i]) begin
            e_ig[i] = 0; e_dg[i] = 0; e_iv[i] = 0; e_dv[i] = 0; e_we[i] = 0; e_idle[i] = 0;
         end
         has_if = 1'($urandom_range(0, 1));
         has_dm = 1'($urandom_range(0, 1));
         if (!has_if && !has_dm) has_if = 1'b1;
         ia  = AW'($urandom_range(0, 127));
         da  = AW'($urandom_range(0, 127));
         dwe = 1'($urandom_range(0, 1));
         dwd = $urandom;
         if (has_if && has_dm) begin
            n = 2; ord[0] = !ref_last_dm; ord[1] = ref_last_dm;
         end else begin
            n = 1; ord[0] = has_dm; ord[1] = 1'b0;
         end
         t = 0;
         for (int j = 0; j < n; j++) begin
            own = ord[j];
            ref_last_dm = own;
            a  = own ? da : ia;
            we = own ? dwe : 1'b0;
            if (own) e_dg[t+1] = 1; else e_ig[t+1] = 1;
            e_addr[t+1] = a;
            if (we) begin
               e_we[t+1] = 1;
               ref_mem[a] = dwd;
               t += 2;
            end else begin
               if (own) e_dv[t+1+LAT] = 1; else e_iv[t+1+LAT] = 1;
               e_data[t+1+LAT] = ref_mem[a];
               t += LAT + 2;
            end
            e_idle[t] = 1;
         end
         n_checks++;
         if (busy !== 1'b0) $display("FAIL rnd_start[%0d]: got busy %b want 0", r, busy);
         else n_pass++;
         if_req = has_if; if_addr = ia;
         dm_req = has_dm; dm_we = dwe; dm_addr = da; dm_wdata = dwd;
         for (int k = 1; k <= t; k++) begin
            @(negedge clk);
            n_checks++;
            if ({if_gnt, dm_gnt, if_rvalid, dm_rvalid, ram_w_en, busy} !==
                {e_ig[k], e_dg[k], e_iv[k], e_dv[k], e_we[k], !e_idle[k]})
               $display("FAIL rnd_ctl[%0d.%0d]: got ig/dg/iv/dv/we/busy %b want %b", r, k,
                        {if_gnt, dm_gnt, if_rvalid, dm_rvalid, ram_w_en, busy},
                        {e_ig[k], e_dg[k], e_iv[k], e_dv[k], e_we[k], !e_idle[k]});
            else n_pass++;
            if (e_ig[k] || e_dg[k]) begin
               n_checks++;
               if (ram_addr !== e_addr[k])
                  $display("FAIL rnd_addr[%0d.%0d]: got %h want %h", r, k, ram_addr, e_addr[k]);
               else n_pass++;
            end
            if (e_iv[k]) begin
               n_checks++;
               if (if_rdata !== e_data[k])
                  $display("FAIL rnd_if_data[%0d]: got %h want %h", r, if_rdata, e_data[k]);
               else n_pass++;
            end
            if (e_dv[k]) begin
               n_checks++;
               if (dm_rdata !== e_data[k])
                  $display("FAIL rnd_dm_data[%0d]: got %h want %h", r, dm_rdata, e_data[k]);
               else n_pass++;
            end
            if (e_ig[k]) if_req = 1'b0;
            if (e_dg[k]) dm_req = 1'b0;
         end
         if_req = 1'b0; dm_req = 1'b0;
         if ($urandom_range(0, 3) == 0) begin
            @(negedge clk);
            n_checks++;
            if (busy !== 1'b0) $display("FAIL rnd_gap[%0d]: got busy %b want 0", r, busy);
            else n_pass++;
         end
      end
   endtask

   task automatic test_rdlat1();
      dm_req1 = 1'b1; dm_we1 = 1'b0; dm_addr1 = 11'h033;
      @(negedge clk);
      n_checks++;
      if (dm_gnt1 !== 1'b1 || busy1 !== 1'b1 || ram_addr1 !== 11'h033)
         $display("FAIL t6_gnt: got g %b busy %b addr %h want 1 1 033",
                  dm_gnt1, busy1, ram_addr1);
      else n_pass++;
      dm_req1 = 1'b0;
      @(negedge clk);
      n_checks++;
      if (dm_rvalid1 !== 1'b1 || dm_rdata1 !== init_mem[7'h33])
         $display("FAIL t6_rvalid: got %b %h want 1 %h", dm_rvalid1, dm_rdata1, init_mem[7'h33]);
      else n_pass++;
      @(negedge clk);
      n_checks++;
      if (dm_rvalid1 !== 1'b0 || busy1 !== 1'b0 || dm_rdata1 !== init_mem[7'h33])
         $display("FAIL t6_after: got rv %b busy %b data %h want 0 0 %h",
                  dm_rvalid1, busy1, dm_rdata1, init_mem[7'h33]);
      else n_pass++;
   endtask

   initial begin
      rst_n = 1'b0;
      if_req = 0; if_addr = '0; dm_req = 0; dm_we = 0; dm_addr = '0; dm_wdata = '0;
      if_req1 = 0; if_addr1 = '0; dm_req1 = 0; dm_we1 = 0; dm_addr1 = '0; dm_wdata1 = '0;
      bd_we = 1'b0; bd_addr = '0; bd_data = '0;
      for (int i = 0; i < 2048; i++) ref_mem[i] = '0;
      for (int i = 0; i < 128; i++) begin
         @(negedge clk);
         init_mem[i] = (i == 16) ? 32'hE3A0_0001 : $urandom;
         ref_mem[i]  = init_mem[i];
         bd_we = 1'b1; bd_addr = AW'(i); bd_data = init_mem[i];
      end
      @(negedge clk);
      bd_we = 1'b0;
      test_reset();
      test_fetch_read();
      test_store();
      test_fairness();
      test_store_load();
      test_reset_mid_wait();
      test_random(40);
      test_rdlat1();
      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

endmodule
